// File: rtl/cpu_pkg.sv
// Shared definitions for the ARMv4T core front end.
//   RESET_PC_DEFAULT : first fetch address after reset
//   MW_*             : mem_width encodings (log2 of the transfer size in bytes)
//   PC_STEP_*        : fetch address increment per instruction in each mode
//   fetch_mode_e     : instruction set state used for fetching
//   fetch_entry_t    : one prefetch queue entry {thumb, pc, instr}
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0800_0000;

  localparam logic [1:0] MW_BYTE = 2'd0;
  localparam logic [1:0] MW_HALF = 2'd1;
  localparam logic [1:0] MW_WORD = 2'd2;

  localparam logic [31:0] PC_STEP_ARM   = 32'd4;
  localparam logic [31:0] PC_STEP_THUMB = 32'd2;

  typedef enum logic {
    MODE_ARM   = 1'b0,
    MODE_THUMB = 1'b1
  } fetch_mode_e;

  typedef struct packed {
    logic        thumb;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/cpu_prefetch_unit_if.sv
// Instruction fetch bus between the prefetch unit and the shared memory port.
// Level-sensitive, one request at a time: a transfer completes in a cycle
// where mem_read and mem_ok are both high; mem_rdata is valid in that cycle.
//   master : prefetch side (drives mem_addr, mem_width, mem_read)
//   slave  : memory side   (drives mem_rdata, mem_ok)
interface cpu_prefetch_unit_if;
  logic [31:0] mem_addr;
  logic [1:0]  mem_width;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_ok;

  modport master (
    output mem_addr,
    output mem_width,
    output mem_read,
    input  mem_rdata,
    input  mem_ok
  );

  modport slave (
    input  mem_addr,
    input  mem_width,
    input  mem_read,
    output mem_rdata,
    output mem_ok
  );
endinterface

// File: rtl/sync_fifo_flush.sv
// Synchronous FIFO with a single-cycle flush.
//   clk, rst     : clock, synchronous active-high reset
//   flush_i      : empties the FIFO at the edge; overrides push and pop
//   push_i       : write wdata_i (ignored when full)
//   wdata_i      : write data
//   pop_i        : advance the head (ignored when empty)
//   rdata_o      : head entry, valid while !empty_o
//   full_o       : count == DEPTH
//   empty_o      : count == 0
//   count_o      : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_flush #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cpu_prefetch_unit.sv
// Instruction prefetch unit for the ARMv4T core.
// Keeps a DEPTH-entry queue filled from the memory bus in ARM (word) or
// Thumb (halfword) mode and flushes it on a redirect.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : redirect request (highest priority after rst)
//   flush_pc     : redirect target, aligned to the new mode internally
//   flush_thumb  : fetch mode after the redirect (1 = Thumb)
//   mem          : fetch bus (master side)
//   out_valid    : queue head valid
//   out_instr    : head instruction (Thumb entries zero-extended)
//   out_pc       : address of the head instruction
//   out_thumb    : mode the head was fetched in
//   out_ready    : consumer accepts the head
//   count        : queue occupancy
module cpu_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  input  logic                 flush_thumb,
  cpu_prefetch_unit_if.master  mem,
  output logic                 out_valid,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_pc,
  output logic                 out_thumb,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     count
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  fetch_mode_e  mode_q,     mode_d;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  // Full is a registered condition, so a pop while full re-opens the bus
  // only in the following cycle.
  assign mem.mem_read  = !rst && !flush && !fifo_full;
  assign mem.mem_addr  = fetch_pc_q;
  assign mem.mem_width = (mode_q == MODE_THUMB) ? MW_HALF : MW_WORD;

  assign push = mem.mem_read && mem.mem_ok;
  assign pop  = out_valid && out_ready;

  assign wr_entry.thumb = (mode_q == MODE_THUMB);
  assign wr_entry.pc    = fetch_pc_q;
  assign wr_entry.instr = (mode_q == MODE_THUMB) ? {16'h0000, mem.mem_rdata[15:0]}
                                                 : mem.mem_rdata;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    mode_d     = mode_q;
    if (flush) begin
      mode_d     = fetch_mode_e'(flush_thumb);
      fetch_pc_d = flush_thumb ? {flush_pc[31:1], 1'b0} : {flush_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + ((mode_q == MODE_THUMB) ? PC_STEP_THUMB : PC_STEP_ARM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      mode_q     <= MODE_ARM;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      mode_q     <= mode_d;
    end
  end

  sync_fifo_flush #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_thumb = head.thumb;

endmodule
